iob_chr_out: RTL and testbench
==============================

# iob_chr_out

Character-output device that sits on the KA10 I/O bus as a responder: the other end of the DATAO/CONO/DATAI/CONI interface that the processor drives. A word written with DATAO is shifted out as six 6-bit characters over a valid/ready stream to a downstream sink (e.g. a punch/printer model). Completion raises a done flag and a priority-interrupt request on the programmed PI level.

## Interface
- DEVICE, 7'o120, device code compared against iobus_ios[3:9]
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; same effect as iobus_iob_reset
- iobus_iob_reset  in  1  bus reset pulse (one clk); clears device like reset
- iobus_ios  in  7 [3:9]  device select code
- iobus_datao_clear  in  1  one-clk pulse; clears buffer if selected
- iobus_datao_set  in  1  one-clk pulse; ORs iobus_iob_out into buffer, starts output, if selected
- iobus_cono_clear  in  1  one-clk pulse; clears PIA, busy, done if selected
- iobus_cono_set  in  1  one-clk pulse; ORs control bits from iobus_iob_out if selected
- iobus_iob_datai  in  1  level; drive buffer onto iobus_iob_in while selected
- iobus_iob_coni  in  1  level; drive status onto iobus_iob_in while selected
- iobus_iob_out  in  36 [0:35]  data from processor
- iobus_iob_in  out  36 [0:35]  data to processor; all zeros unless a read is selected (wired-OR bus)
- iobus_pi  out  7 [1:7]  PI request, one-hot on level PIA
- chr_data  out  6 [0:5]  current character
- chr_valid  out  1  character available
- chr_ready  in  1  sink accepts when chr_valid & chr_ready at a clk edge

## Operation
- sel = (iobus_ios == DEVICE). All bus strobes ignored when sel is 0.
- State: buf[0:35], cnt (0..6), pia[0:2], busy, done.
- DATAO clear: buf <= 0. DATAO set: buf <= buf | iob_out; cnt <= 0; busy <= 1; done <= 0. Set while busy restarts at character 0 with the ORed word.
- Output: while busy, chr_valid = 1, chr_data = buf[0:5]. On accept: buf <= {buf[6:35], 6'b0}, cnt <= cnt+1. On accepting character with cnt==5: busy <= 0, done <= 1, cnt <= 0.
- CONO clear: pia <= 0, busy <= 0, done <= 0 (aborts output; chr_valid drops next cycle). CONO set: pia <= pia | iob_out[33:35]; iob_out[32] sets done; iob_out[31] clears done (clear wins over set).
- Same-cycle priority: clear strobe applied before set strobe for both DATAO and CONO (set result = 0 | iob_out bits); DATAO set wins over a simultaneous final-character accept (restart, done stays 0).
- CONI word: bits 0:17 zero; [29:30] zero; [31] busy; [32] done; [33:35] pia; remaining bits zero. Bits 18:28 zero.
- DATAI word: current buf (partially shifted if mid-output).
- iobus_iob_in = (sel & datai ? buf : 0) | (sel & coni ? status : 0).
- iobus_pi[n] = done & (pia == n), n = 1..7; pia == 0 requests nothing.

## Timing
- Reset/iob_reset: buf=0, cnt=0, pia=0, busy=0, done=0; outputs chr_valid=0, chr_data=0, iobus_pi=0, iobus_iob_in=0. Reset mid-output aborts without further handshake.
- chr_valid rises the cycle after DATAO set; with chr_ready held high, six characters transfer in six consecutive cycles; done and PI request visible the cycle after the sixth accept (7 cycles after DATAO set edge).
- chr_valid never drops without an accept except on CONO clear, iob_reset or reset; chr_data stable while chr_valid & !chr_ready.
- iobus_iob_in and iobus_pi are combinational from registers and bus inputs; no added latency.

## Test plan
- Reset: assert reset 2 cycles -> all outputs 0, CONI (ios=DEVICE) reads 0.
- CONO set iob_out=0o000000_000005 -> pia=5, CONI returns 0o5; DATAO clear+set 0o010203_040506, chr_ready=1 -> chars 01,02,03,04,05,06 on consecutive cycles, then CONI=0o15, iobus_pi=7'b0000100.
- Backpressure: chr_ready toggled 0/1 every cycle -> same six chars, no duplicate/skip, data stable while stalled, done after 12 cycles.
- Wrong device: strobes with ios≠DEVICE -> no state change, iobus_iob_in stays 0.
- CONO clear after 3 characters -> chr_valid 0 next cycle, busy=done=pia=0, DATAI returns word shifted left 18 bits.
- Collision: DATAO set in the cycle the sixth char is accepted -> done stays 0, output restarts from character 0 of new word.

Source files
------------

// File: rtl/iob_chr_out.sv
// KA10 I/O bus responder that shifts a DATAO word out as six 6-bit characters.
// Latency: chr_valid one cycle after DATAO set; bus reads and PI requests are combinational.
// Backpressure: a character holds on chr_data until chr_ready; only CONO clear or reset withdraws it.
module iob_chr_out (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic [3:9]  iobus_ios,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_datai,
    input  logic        iobus_iob_coni,
    input  logic [0:35] iobus_iob_out,
    output logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi,
    output logic [0:5]  chr_data,
    output logic        chr_valid,
    input  logic        chr_ready
);

    localparam logic [3:9] DEVICE = 7'o120;

    logic [0:35] data_buf, n_buf;
    logic [2:0]  cnt, n_cnt;
    logic [0:2]  pia, n_pia;
    logic        busy, n_busy;
    logic        done, n_done;
    logic        sel;
    logic [0:35] status;

    assign sel = (iobus_ios == DEVICE);

    // Handshake first, then CONO, then DATAO: a DATAO set in the same cycle as the
    // final accept ORs into the already-emptied buffer and restarts cleanly.
    always_comb begin
        n_buf  = data_buf;
        n_cnt  = cnt;
        n_pia  = pia;
        n_busy = busy;
        n_done = done;
        if (busy && chr_ready) begin
            n_buf = {data_buf[6:35], 6'b0};
            if (cnt == 3'd5) begin
                n_busy = 1'b0;
                n_done = 1'b1;
                n_cnt  = 3'd0;
            end else begin
                n_cnt = cnt + 3'd1;
            end
        end
        if (sel && iobus_cono_clear) begin
            n_pia  = 3'b0;
            n_busy = 1'b0;
            n_done = 1'b0;
        end
        if (sel && iobus_cono_set) begin
            n_pia = n_pia | iobus_iob_out[33:35];
            if (iobus_iob_out[32]) n_done = 1'b1;
            if (iobus_iob_out[31]) n_done = 1'b0;
        end
        if (sel && iobus_datao_clear) begin
            n_buf = 36'b0;
        end
        if (sel && iobus_datao_set) begin
            n_buf  = n_buf | iobus_iob_out;
            n_cnt  = 3'd0;
            n_busy = 1'b1;
            n_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || iobus_iob_reset) begin
            data_buf <= 36'b0;
            cnt      <= 3'd0;
            pia      <= 3'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            data_buf <= n_buf;
            cnt      <= n_cnt;
            pia      <= n_pia;
            busy     <= n_busy;
            done     <= n_done;
        end
    end

    assign chr_valid = busy;
    assign chr_data  = busy ? data_buf[0:5] : 6'b0;

    always_comb begin
        status        = 36'b0;
        status[31]    = busy;
        status[32]    = done;
        status[33:35] = pia;
    end

    assign iobus_iob_in = ((sel && iobus_iob_datai) ? data_buf : 36'b0)
                        | ((sel && iobus_iob_coni)  ? status   : 36'b0);

    always_comb begin
        for (int n = 1; n <= 7; n++) begin
            iobus_pi[n] = done && (pia == 3'(n));
        end
    end

endmodule

// File: tb/tb_iob_chr_out.sv
// Directed bench for iob_chr_out: drives bus strobes on the falling edge and checks outputs there.
module tb_iob_chr_out;

    localparam logic [3:9] DEV = 7'o120;

    logic        clk = 1'b0;
    logic        reset;
    logic        iobus_iob_reset;
    logic [3:9]  iobus_ios;
    logic        iobus_datao_clear;
    logic        iobus_datao_set;
    logic        iobus_cono_clear;
    logic        iobus_cono_set;
    logic        iobus_iob_datai;
    logic        iobus_iob_coni;
    logic [0:35] iobus_iob_out;
    logic [0:35] iobus_iob_in;
    logic [1:7]  iobus_pi;
    logic [0:5]  chr_data;
    logic        chr_valid;
    logic        chr_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iob_chr_out dut (
        .clk               (clk),
        .reset             (reset),
        .iobus_iob_reset   (iobus_iob_reset),
        .iobus_ios         (iobus_ios),
        .iobus_datao_clear (iobus_datao_clear),
        .iobus_datao_set   (iobus_datao_set),
        .iobus_cono_clear  (iobus_cono_clear),
        .iobus_cono_set    (iobus_cono_set),
        .iobus_iob_datai   (iobus_iob_datai),
        .iobus_iob_coni    (iobus_iob_coni),
        .iobus_iob_out     (iobus_iob_out),
        .iobus_iob_in      (iobus_iob_in),
        .iobus_pi          (iobus_pi),
        .chr_data          (chr_data),
        .chr_valid         (chr_valid),
        .chr_ready         (chr_ready)
    );

    // One-cycle strobe pulse, issued at the current falling edge.
    task automatic strobe(input logic dc, input logic ds, input logic cc, input logic cs,
                          input logic [35:0] w);
        iobus_datao_clear = dc;
        iobus_datao_set   = ds;
        iobus_cono_clear  = cc;
        iobus_cono_set    = cs;
        iobus_iob_out     = w;
        @(negedge clk);
        iobus_datao_clear = 1'b0;
        iobus_datao_set   = 1'b0;
        iobus_cono_clear  = 1'b0;
        iobus_cono_set    = 1'b0;
        iobus_iob_out     = 36'b0;
    endtask

    task automatic read_bus(input logic di, input logic co, output logic [35:0] v);
        iobus_iob_datai = di;
        iobus_iob_coni  = co;
        #1;
        v = iobus_iob_in;
        iobus_iob_datai = 1'b0;
        iobus_iob_coni  = 1'b0;
    endtask

    task automatic test_reset;
        logic [35:0] v;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (chr_valid !== 1'b0 || chr_data !== 6'o00 || iobus_pi !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs valid=%b data=%o pi=%b, want 0/00/0000000",
                     chr_valid, chr_data, iobus_pi);
        end
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o0) begin
            fails++;
            $display("FAIL reset_coni got %012o want %012o", v, 36'o0);
        end
    endtask

    task automatic test_basic;
        logic [35:0] v;
        logic [35:0] w = 36'o010203_040506;
        strobe(1'b0, 1'b0, 1'b0, 1'b1, 36'o000000_000005);
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o5) begin
            fails++;
            $display("FAIL cono_pia got %012o want %012o", v, 36'o5);
        end
        chr_ready = 1'b1;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, w);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (chr_valid !== 1'b1 || chr_data !== 6'((w >> (30 - 6 * i)) & 36'o77)) begin
                fails++;
                $display("FAIL basic_char%0d valid=%b data=%o want 1/%o", i, chr_valid, chr_data,
                         6'((w >> (30 - 6 * i)) & 36'o77));
            end
            @(negedge clk);
        end
        tests++;
        if (chr_valid !== 1'b0 || iobus_pi !== 7'b0000100) begin
            fails++;
            $display("FAIL basic_done valid=%b pi=%b want 0/0000100", chr_valid, iobus_pi);
        end
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o15) begin
            fails++;
            $display("FAIL basic_coni got %012o want %012o", v, 36'o15);
        end
    endtask

    task automatic test_backpressure;
        logic [35:0] v;
        logic [35:0] w = 36'o111213_141516;
        chr_ready = 1'b0;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, w);
        for (int c = 0; c < 12; c++) begin
            chr_ready = c[0];
            #1;
            tests++;
            if (chr_valid !== 1'b1 || chr_data !== 6'((w >> (30 - 6 * (c / 2))) & 36'o77)) begin
                fails++;
                $display("FAIL bp_cycle%0d valid=%b data=%o want 1/%o", c, chr_valid, chr_data,
                         6'((w >> (30 - 6 * (c / 2))) & 36'o77));
            end
            @(negedge clk);
        end
        chr_ready = 1'b0;
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o15 || chr_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_done coni=%012o valid=%b want %012o/0", v, chr_valid, 36'o15);
        end
    endtask

    task automatic test_wrong_device;
        logic [35:0] v;
        iobus_ios = 7'o121;
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 36'o0);
        strobe(1'b1, 1'b1, 1'b0, 1'b1, 36'o777777_777777);
        read_bus(1'b1, 1'b1, v);
        tests++;
        if (v !== 36'o0 || chr_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrongdev_bus in=%012o valid=%b want 0/0", v, chr_valid);
        end
        iobus_ios = DEV;
        read_bus(1'b1, 1'b1, v);
        tests++;
        if (v !== 36'o15 || iobus_pi !== 7'b0000100) begin
            fails++;
            $display("FAIL wrongdev_state in=%012o pi=%b want %012o/0000100", v, iobus_pi, 36'o15);
        end
    endtask

    task automatic test_cono_clear;
        logic [35:0] v;
        chr_ready = 1'b1;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 36'o010203_040506);
        repeat (3) @(negedge clk);
        chr_ready = 1'b0;
        tests++;
        if (chr_valid !== 1'b1 || chr_data !== 6'o04) begin
            fails++;
            $display("FAIL abort_pre valid=%b data=%o want 1/04", chr_valid, chr_data);
        end
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 36'o0);
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (chr_valid !== 1'b0 || v !== 36'o0 || iobus_pi !== 7'b0) begin
            fails++;
            $display("FAIL abort_state valid=%b coni=%012o pi=%b want 0/0/0", chr_valid, v, iobus_pi);
        end
        read_bus(1'b1, 1'b0, v);
        tests++;
        if (v !== 36'o040506_000000) begin
            fails++;
            $display("FAIL abort_datai got %012o want %012o", v, 36'o040506_000000);
        end
    endtask

    task automatic test_back_to_back;
        logic [35:0] v;
        logic [35:0] wb = 36'o313233_343536;
        strobe(1'b0, 1'b0, 1'b0, 1'b1, 36'o3);
        chr_ready = 1'b1;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 36'o212223_242526);
        repeat (5) @(negedge clk);
        tests++;
        if (chr_data !== 6'o26) begin
            fails++;
            $display("FAIL b2b_last got %o want 26", chr_data);
        end
        strobe(1'b1, 1'b1, 1'b0, 1'b0, wb);
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o23 || iobus_pi !== 7'b0) begin
            fails++;
            $display("FAIL b2b_restart coni=%012o pi=%b want %012o/0000000", v, iobus_pi, 36'o23);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (chr_valid !== 1'b1 || chr_data !== 6'((wb >> (30 - 6 * i)) & 36'o77)) begin
                fails++;
                $display("FAIL b2b_char%0d valid=%b data=%o want 1/%o", i, chr_valid, chr_data,
                         6'((wb >> (30 - 6 * i)) & 36'o77));
            end
            @(negedge clk);
        end
        read_bus(1'b0, 1'b1, v);
        tests++;
        if (v !== 36'o13 || iobus_pi !== 7'b0010000) begin
            fails++;
            $display("FAIL b2b_done coni=%012o pi=%b want %012o/0010000", v, iobus_pi, 36'o13);
        end
    endtask

    task automatic test_iob_reset;
        logic [35:0] v;
        chr_ready = 1'b0;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 36'o414243_444546);
        iobus_iob_reset = 1'b1;
        @(negedge clk);
        iobus_iob_reset = 1'b0;
        read_bus(1'b1, 1'b1, v);
        tests++;
        if (chr_valid !== 1'b0 || v !== 36'o0 || iobus_pi !== 7'b0) begin
            fails++;
            $display("FAIL iob_reset valid=%b in=%012o pi=%b want 0/0/0", chr_valid, v, iobus_pi);
        end
    endtask

    initial begin
        reset             = 1'b1;
        iobus_iob_reset   = 1'b0;
        iobus_ios         = DEV;
        iobus_datao_clear = 1'b0;
        iobus_datao_set   = 1'b0;
        iobus_cono_clear  = 1'b0;
        iobus_cono_set    = 1'b0;
        iobus_iob_datai   = 1'b0;
        iobus_iob_coni    = 1'b0;
        iobus_iob_out     = 36'b0;
        chr_ready         = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_wrong_device;
        test_cono_clear;
        test_back_to_back;
        test_iob_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
